seg_scan_reader: RTL and testbench

Receive-side companion to the team's 7-segment decoders. It samples a multiplexed display bus: one-hot digit enables plus the 7 segment lines. For each digit it recovers the 4-bit hex value, its valid flag and a frame-complete strobe. It sits between the display pins (or a display model) and any checker or host logic that needs the shown digits back in binary.

---
 rtl/seg_scan_reader.sv | 169 ++++++++++++++++
 tb/tb_seg_scan_reader.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/seg_scan_reader.sv
// Recovers hex digits from a multiplexed 7-segment bus (one-hot digit enables plus segments).
// Each stable {an,seg} phase is captured once, decoded, and accounted toward a full-frame strobe.
module seg_scan_reader #(
  parameter int NUM_DIGITS = 4,
  parameter int STABLE_CNT = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_DIGITS-1:0]   an,
  input  logic [6:0]              seg,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic [NUM_DIGITS-1:0]   digit_valid,
  output logic                    frame_done,
  output logic                    bad_pat
);

  localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [3:0] CNT_MAX = 4'(STABLE_CNT);

  typedef enum logic [1:0] {IDLE, COUNT, CAPTURE, DONE} state_t;

  // Returns {legal, value}; blank and unknown patterns both report legal=0.
  function automatic logic [4:0] decode_seg(input logic [6:0] s);
    case (s)
      7'h3F: decode_seg = {1'b1, 4'h0};
      7'h06: decode_seg = {1'b1, 4'h1};
      7'h5B: decode_seg = {1'b1, 4'h2};
      7'h4F: decode_seg = {1'b1, 4'h3};
      7'h66: decode_seg = {1'b1, 4'h4};
      7'h6D: decode_seg = {1'b1, 4'h5};
      7'h7D: decode_seg = {1'b1, 4'h6};
      7'h07: decode_seg = {1'b1, 4'h7};
      7'h7F: decode_seg = {1'b1, 4'h8};
      7'h6F: decode_seg = {1'b1, 4'h9};
      7'h77: decode_seg = {1'b1, 4'hA};
      7'h7C: decode_seg = {1'b1, 4'hB};
      7'h39: decode_seg = {1'b1, 4'hC};
      7'h5E: decode_seg = {1'b1, 4'hD};
      7'h79: decode_seg = {1'b1, 4'hE};
      7'h71: decode_seg = {1'b1, 4'hF};
      default: decode_seg = 5'b0;
    endcase
  endfunction

  function automatic logic is_onehot(input logic [NUM_DIGITS-1:0] v);
    int n;
    n = 0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) n++;
    end
    is_onehot = (n == 1);
  endfunction

  function automatic logic [IDX_W-1:0] onehot_idx(input logic [NUM_DIGITS-1:0] v);
    onehot_idx = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      if (v[i]) onehot_idx = IDX_W'(i);
    end
  endfunction

  logic [NUM_DIGITS-1:0]   an_s1_q, an_s1_d, an_s2_q, an_s2_d;
  logic [6:0]              seg_s1_q, seg_s1_d, seg_s2_q, seg_s2_d;
  logic [NUM_DIGITS-1:0]   hold_an_q, hold_an_d;
  logic [6:0]              hold_seg_q, hold_seg_d;
  logic [3:0]              cnt_q, cnt_d;
  state_t                  state_q, state_d;
  logic [4*NUM_DIGITS-1:0] digits_q, digits_d;
  logic [NUM_DIGITS-1:0]   valid_q, valid_d;
  logic [NUM_DIGITS-1:0]   seen_q, seen_d;
  logic                    frame_done_q, frame_done_d;
  logic                    bad_pat_q, bad_pat_d;

  logic                    changed;
  logic [4:0]              dec;
  logic [IDX_W-1:0]        idx;
  logic [NUM_DIGITS-1:0]   seen_new;

  always_comb begin
    an_s1_d    = an;
    an_s2_d    = an_s1_q;
    seg_s1_d   = seg;
    seg_s2_d   = seg_s1_q;

    // Held sample always tracks the synchronized bus; the counter measures how long it has matched.
    changed    = {an_s2_q, seg_s2_q} != {hold_an_q, hold_seg_q};
    hold_an_d  = an_s2_q;
    hold_seg_d = seg_s2_q;
    if (changed)              cnt_d = 4'd1;
    else if (cnt_q < CNT_MAX) cnt_d = cnt_q + 4'd1;
    else                      cnt_d = cnt_q;

    state_d = state_q;
    if (changed) begin
      state_d = is_onehot(an_s2_q) ? COUNT : IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = IDLE;
        COUNT:   state_d = (cnt_d == CNT_MAX) ? CAPTURE : COUNT;
        CAPTURE: state_d = DONE;
        default: state_d = DONE;
      endcase
    end

    digits_d     = digits_q;
    valid_d      = valid_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    bad_pat_d    = 1'b0;
    dec          = decode_seg(hold_seg_q);
    idx          = onehot_idx(hold_an_q);
    seen_new     = seen_q;
    seen_new[idx] = 1'b1;

    if (state_q == CAPTURE) begin
      if (dec[4]) begin
        digits_d[4*idx +: 4] = dec[3:0];
        valid_d[idx]         = 1'b1;
      end else begin
        valid_d[idx] = 1'b0;
        bad_pat_d    = (hold_seg_q != 7'h00);
      end
      // Completing the mask fires the strobe and starts the next frame empty.
      if (&seen_new) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end else begin
        seen_d = seen_new;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      an_s1_q      <= '0;
      an_s2_q      <= '0;
      seg_s1_q     <= '0;
      seg_s2_q     <= '0;
      hold_an_q    <= '0;
      hold_seg_q   <= '0;
      cnt_q        <= '0;
      state_q      <= IDLE;
      digits_q     <= '0;
      valid_q      <= '0;
      seen_q       <= '0;
      frame_done_q <= 1'b0;
      bad_pat_q    <= 1'b0;
    end else begin
      an_s1_q      <= an_s1_d;
      an_s2_q      <= an_s2_d;
      seg_s1_q     <= seg_s1_d;
      seg_s2_q     <= seg_s2_d;
      hold_an_q    <= hold_an_d;
      hold_seg_q   <= hold_seg_d;
      cnt_q        <= cnt_d;
      state_q      <= state_d;
      digits_q     <= digits_d;
      valid_q      <= valid_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      bad_pat_q    <= bad_pat_d;
    end
  end

  assign digits      = digits_q;
  assign digit_valid = valid_q;
  assign frame_done  = frame_done_q;
  assign bad_pat     = bad_pat_q;

endmodule

// File: tb/tb_seg_scan_reader.sv
// Directed bench for seg_scan_reader: capture timing, glitch rejection, frames, bad/blank patterns, reset.
module tb_seg_scan_reader;

  logic        clk;
  logic        rst_n;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_valid;
  logic        frame_done;
  logic        bad_pat;

  int unsigned n_checks;
  int unsigned n_errors;
  int unsigned fd_cnt;
  int unsigned bp_cnt;
  int unsigned f0, b0, f1;

  seg_scan_reader #(.NUM_DIGITS(4), .STABLE_CNT(3)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_valid (digit_valid),
    .frame_done  (frame_done),
    .bad_pat     (bad_pat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Each cycle of a pulse output counts once, so a stretched pulse shows up as an extra event.
  always @(negedge clk) begin
    if (rst_n) begin
      if (frame_done) fd_cnt++;
      if (bad_pat)    bp_cnt++;
    end
  end

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // Called just after a falling edge; holds the bus for n rising edges.
  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    an  = a;
    seg = s;
    repeat (n) @(negedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    fd_cnt   = 0;
    bp_cnt   = 0;
    rst_n    = 1'b0;
    an       = '0;
    seg      = '0;

    repeat (4) begin
      @(negedge clk);
      an  = 4'($urandom_range(0, 15));
      seg = 7'($urandom_range(0, 127));
    end
    #1;
    check("rst_digits", 32'(digits), 32'h0);
    check("rst_valid", 32'(digit_valid), 32'h0);
    check("rst_frame_done", 32'(frame_done), 32'h0);
    check("rst_bad_pat", 32'(bad_pat), 32'h0);

    @(negedge clk);
    rst_n = 1'b1;
    an    = '0;
    seg   = '0;
    repeat (3) @(negedge clk);
    #1;
    check("idle_digits", 32'(digits), 32'h0);
    check("idle_valid", 32'(digit_valid), 32'h0);

    // Capture lands on the sixth rising edge after the bus changes.
    an  = 4'b0001;
    seg = 7'h4F;
    repeat (5) @(negedge clk);
    #1;
    check("edge5_valid", 32'(digit_valid), 32'h0);
    @(negedge clk);
    #1;
    check("edge6_digits", 32'(digits), 32'h0003);
    check("edge6_valid", 32'(digit_valid), 32'h1);
    repeat (4) @(negedge clk);
    #1;
    check("first_no_frame", fd_cnt, 0);

    drive(4'b0010, 7'h06, 2);
    drive(4'b0000, 7'h00, 6);
    check("glitch_digits", 32'(digits), 32'h0003);
    check("glitch_valid", 32'(digit_valid), 32'h1);
    drive(4'b0010, 7'h06, 8);
    check("d1_digits", 32'(digits), 32'h0013);
    check("d1_valid", 32'(digit_valid), 32'h3);

    f0 = fd_cnt;
    drive(4'b0001, 7'h06, 8);
    drive(4'b0010, 7'h5B, 8);
    drive(4'b0100, 7'h4F, 8);
    check("scan1_pre_frame", fd_cnt, f0);
    drive(4'b1000, 7'h66, 8);
    check("scan1_frame", fd_cnt, f0 + 1);
    check("scan1_digits", 32'(digits), 32'h4321);
    check("scan1_valid", 32'(digit_valid), 32'hF);
    drive(4'b0001, 7'h06, 8);
    drive(4'b0010, 7'h5B, 8);
    drive(4'b0100, 7'h4F, 8);
    check("scan2_pre_frame", fd_cnt, f0 + 1);
    drive(4'b1000, 7'h66, 8);
    check("scan2_frame", fd_cnt, f0 + 2);

    b0 = bp_cnt;
    drive(4'b0100, 7'h01, 8);
    check("bad_pulse", bp_cnt, b0 + 1);
    check("bad_valid", 32'(digit_valid), 32'hB);
    check("bad_digits", 32'(digits), 32'h4321);
    drive(4'b0100, 7'h00, 8);
    check("blank_valid", 32'(digit_valid), 32'hB);
    check("blank_no_bad", bp_cnt, b0 + 1);
    check("blank_digits", 32'(digits), 32'h4321);

    drive(4'b0011, 7'h7F, 20);
    check("multi_digits", 32'(digits), 32'h4321);
    check("multi_valid", 32'(digit_valid), 32'hB);
    check("multi_no_frame", fd_cnt, f0 + 2);
    check("multi_no_bad", bp_cnt, b0 + 1);

    drive(4'b0001, 7'h7F, 8);
    drive(4'b0010, 7'h07, 8);
    drive(4'b0100, 7'h7D, 8);
    check("part_digits", 32'(digits), 32'h4678);
    check("part_valid", 32'(digit_valid), 32'hF);
    check("part_no_frame", fd_cnt, f0 + 2);

    rst_n = 1'b0;
    an    = '0;
    seg   = '0;
    #1;
    check("midrst_digits", 32'(digits), 32'h0);
    check("midrst_valid", 32'(digit_valid), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    f1 = fd_cnt;
    drive(4'b0001, 7'h06, 8);
    drive(4'b0010, 7'h5B, 8);
    drive(4'b0100, 7'h4F, 8);
    check("post_rst_pre_frame", fd_cnt, f1);
    drive(4'b1000, 7'h66, 8);
    check("post_rst_frame", fd_cnt, f1 + 1);
    check("post_rst_digits", 32'(digits), 32'h4321);
    check("post_rst_valid", 32'(digit_valid), 32'hF);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
